// File: rtl/stage_mem_if.sv
// Execute -> memory -> write-back stage bus: handshake, latched control,
// SRAM read data and the register-file / bypass outputs.
interface stage_mem_if;
  logic        validin;
  logic        allowin;
  logic        allowout;
  logic        validout;
  logic [31:0] input_pc;
  logic [31:0] output_pc;
  logic [4:0]  input_rf_waddr;
  logic        input_rf_we;
  logic [4:0]  output_rf_waddr;
  logic        output_rf_we;
  logic [31:0] input_alu_result;
  logic        input_mem_read;
  logic [2:0]  input_mem_op;
  logic [31:0] data_sram_rdata;
  logic [31:0] output_rf_wdata;
  logic        fwd_we;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;

  modport slave (
    input  validin, allowout, input_pc, input_rf_waddr, input_rf_we,
           input_alu_result, input_mem_read, input_mem_op, data_sram_rdata,
    output allowin, validout, output_pc, output_rf_waddr, output_rf_we,
           output_rf_wdata, fwd_we, fwd_waddr, fwd_wdata
  );

  modport master (
    output validin, allowout, input_pc, input_rf_waddr, input_rf_we,
           input_alu_result, input_mem_read, input_mem_op, data_sram_rdata,
    input  allowin, validout, output_pc, output_rf_waddr, output_rf_we,
           output_rf_wdata, fwd_we, fwd_waddr, fwd_wdata
  );
endinterface

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: latches execute results, captures SRAM read data,
// aligns loads. Define MEM_SUBWORD_EN to enable byte/half loads with extension.
module stage_mem #(
  parameter logic [31:0] PC_RESET  = 32'h0,
  parameter int          RDATA_LAT = 1
) (
  input logic        clk,
  input logic        rst,
  stage_mem_if.slave bus
);

  generate
    if (RDATA_LAT != 1) begin : g_lat_check
      $error("stage_mem: only RDATA_LAT == 1 is supported");
    end
  endgenerate

  logic        valid_r;
  logic [31:0] pc_r;
  logic [4:0]  rf_waddr_r;
  logic        rf_we_r;
  logic [31:0] alu_result_r;
  logic        mem_read_r;
  logic        fresh_r;
  logic [31:0] rdata_hold_r;
`ifdef MEM_SUBWORD_EN
  logic [2:0]  mem_op_r;
`endif

  logic        allowin_s;
  logic        flush_s;
  logic [31:0] load_word_s;
  logic [31:0] load_ext_s;
  logic [31:0] wdata_s;
  logic        rf_we_s;

`ifdef MEM_SUBWORD_EN
  function automatic logic [31:0] load_align(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [2:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (op[1:0])
      2'b01:   r = op[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b10:   r = op[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction
`endif

  // Pipeline valid, first-cycle marker, read-data hold and latched payload
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r      <= 1'b0;
      pc_r         <= PC_RESET;
      rf_waddr_r   <= 5'd0;
      rf_we_r      <= 1'b0;
      alu_result_r <= 32'h0;
      mem_read_r   <= 1'b0;
      fresh_r      <= 1'b0;
      rdata_hold_r <= 32'h0;
`ifdef MEM_SUBWORD_EN
      mem_op_r     <= 3'd0;
`endif
    end else begin
      valid_r <= flush_s ? 1'b1 : (bus.allowout ? 1'b0 : valid_r);
      fresh_r <= flush_s;
      // SRAM output is only valid in the first cycle; keep it for stalls
      if (fresh_r) begin
        rdata_hold_r <= bus.data_sram_rdata;
      end
      if (flush_s) begin
        pc_r         <= bus.input_pc;
        rf_waddr_r   <= bus.input_rf_waddr;
        rf_we_r      <= bus.input_rf_we;
        alu_result_r <= bus.input_alu_result;
        mem_read_r   <= bus.input_mem_read;
`ifdef MEM_SUBWORD_EN
        mem_op_r     <= bus.input_mem_op;
`endif
      end
    end
  end

  // Handshake, load data selection and write-back / bypass outputs
  always_comb begin
    allowin_s   = !valid_r | bus.allowout;
    flush_s     = bus.validin & allowin_s;
    load_word_s = fresh_r ? bus.data_sram_rdata : rdata_hold_r;
`ifdef MEM_SUBWORD_EN
    load_ext_s  = load_align(load_word_s, alu_result_r[1:0], mem_op_r);
`else
    load_ext_s  = load_word_s;
`endif
    if (mem_read_r) begin
      wdata_s = load_ext_s;
    end else begin
      wdata_s = alu_result_r;
    end
    rf_we_s = valid_r & rf_we_r;

    bus.allowin         = allowin_s;
    bus.validout        = valid_r;
    bus.output_pc       = pc_r;
    bus.output_rf_waddr = rf_waddr_r;
    bus.output_rf_we    = rf_we_s;
    bus.output_rf_wdata = wdata_s;
    bus.fwd_we          = rf_we_s & (rf_waddr_r != 5'd0);
    bus.fwd_waddr       = rf_waddr_r;
    bus.fwd_wdata       = wdata_s;
  end

endmodule

// File: tb/tb_stage_mem.sv
// Self-checking bench for stage_mem: table-driven single-cycle vectors plus
// directed stall, refill, reset and back-to-back sequences.
module tb_stage_mem;

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;

  stage_mem_if bus ();

  stage_mem #(.PC_RESET(32'h0), .RDATA_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [4:0]  waddr;
    logic        we;
    logic        mr;
    logic [2:0]  op;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_fwd;
  } vec_t;

  vec_t vecs[11];

  // Expected subword result; word-only build returns the whole word
  function automatic logic [31:0] subw(input logic [31:0] sub, input logic [31:0] word);
`ifdef MEM_SUBWORD_EN
    return sub;
`else
    return word;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vin, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [4:0] waddr, input logic we, input logic mr,
                       input logic [2:0] op);
    bus.validin          = vin;
    bus.input_pc         = pc;
    bus.input_alu_result = alu;
    bus.input_rf_waddr   = waddr;
    bus.input_rf_we      = we;
    bus.input_mem_read   = mr;
    bus.input_mem_op     = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    vecs[0]  = '{32'h1c000010, 32'h00001234, 5'd5, 1'b1, 1'b0, 3'b000, 32'hA5A5A5A5, 32'h00001234, 1'b1};
    vecs[1]  = '{32'h1c000014, 32'h00005555, 5'd0, 1'b1, 1'b0, 3'b000, 32'hA5A5A5A5, 32'h00005555, 1'b0};
    vecs[2]  = '{32'h1c000018, 32'h00000100, 5'd9, 1'b1, 1'b1, 3'b000, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    vecs[3]  = '{32'h1c00001c, 32'h0000BEEF, 5'd7, 1'b0, 1'b0, 3'b000, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[4]  = '{32'h1c000020, 32'h00000101, 5'd1, 1'b1, 1'b1, 3'b001, 32'h80F17F02, subw(32'h0000007F, 32'h80F17F02), 1'b1};
    vecs[5]  = '{32'h1c000024, 32'h00000103, 5'd2, 1'b1, 1'b1, 3'b001, 32'h80F17F02, subw(32'hFFFFFF80, 32'h80F17F02), 1'b1};
    vecs[6]  = '{32'h1c000028, 32'h00000103, 5'd3, 1'b1, 1'b1, 3'b101, 32'h80F17F02, subw(32'h00000080, 32'h80F17F02), 1'b1};
    vecs[7]  = '{32'h1c00002c, 32'h00000102, 5'd4, 1'b1, 1'b1, 3'b010, 32'h80F17F02, subw(32'hFFFF80F1, 32'h80F17F02), 1'b1};
    vecs[8]  = '{32'h1c000030, 32'h00000100, 5'd6, 1'b1, 1'b1, 3'b110, 32'h80F17F02, subw(32'h00007F02, 32'h80F17F02), 1'b1};
    vecs[9]  = '{32'h1c000034, 32'h00000103, 5'd8, 1'b1, 1'b1, 3'b010, 32'h80F17F02, subw(32'hFFFF80F1, 32'h80F17F02), 1'b1};
    vecs[10] = '{32'h1c000038, 32'h00000101, 5'd10, 1'b1, 1'b1, 3'b011, 32'h80F17F02, 32'h80F17F02, 1'b1};

    // Reset held with a valid upstream instruction present
    rst = 1'b1;
    bus.allowout = 1'b1;
    bus.data_sram_rdata = 32'h0;
    drive(1'b1, 32'h12345678, 32'h1, 5'd3, 1'b1, 1'b0, 3'b000);
    tick();
    tick();
    chk("reset_validout", {31'h0, bus.validout}, 32'h0);
    chk("reset_allowin", {31'h0, bus.allowin}, 32'h1);
    chk("reset_rf_we", {31'h0, bus.output_rf_we}, 32'h0);
    chk("reset_fwd_we", {31'h0, bus.fwd_we}, 32'h0);
    chk("reset_pc", bus.output_pc, 32'h0);
    chk("reset_wdata", bus.output_rf_wdata, 32'h0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
    tick();
    rst = 1'b0;

    // Table vectors, issued back to back with downstream always ready
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].pc, vecs[i].alu, vecs[i].waddr, vecs[i].we, vecs[i].mr, vecs[i].op);
      tick();
      bus.data_sram_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_validout", i), {31'h0, bus.validout}, 32'h1);
      chk($sformatf("v%0d_pc", i), bus.output_pc, vecs[i].pc);
      chk($sformatf("v%0d_wdata", i), bus.output_rf_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d_fwd_wdata", i), bus.fwd_wdata, vecs[i].exp_wdata);
      chk($sformatf("v%0d_rf_we", i), {31'h0, bus.output_rf_we}, {31'h0, vecs[i].we});
      chk($sformatf("v%0d_fwd_we", i), {31'h0, bus.fwd_we}, {31'h0, vecs[i].exp_fwd});
      chk($sformatf("v%0d_fwd_waddr", i), {27'h0, bus.fwd_waddr}, {27'h0, vecs[i].waddr});
    end
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
    tick();
    chk("drain_validout", {31'h0, bus.validout}, 32'h0);

    // Load held by a 3-cycle downstream stall while the SRAM output changes
    drive(1'b1, 32'h1c000100, 32'h00000100, 5'd12, 1'b1, 1'b1, 3'b000);
    tick();
    bus.data_sram_rdata = 32'hDEADBEEF;
    bus.allowout = 1'b0;
    drive(1'b1, 32'h1c000200, 32'h00000777, 5'd13, 1'b1, 1'b0, 3'b000);
    #1;
    chk("stall0_wdata", bus.output_rf_wdata, 32'hDEADBEEF);
    chk("stall0_allowin", {31'h0, bus.allowin}, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.data_sram_rdata = 32'h0;
      #1;
      chk($sformatf("stall%0d_wdata", c), bus.output_rf_wdata, 32'hDEADBEEF);
      chk($sformatf("stall%0d_allowin", c), {31'h0, bus.allowin}, 32'h0);
      chk($sformatf("stall%0d_validout", c), {31'h0, bus.validout}, 32'h1);
      chk($sformatf("stall%0d_pc", c), bus.output_pc, 32'h1c000100);
    end

    // Release the stall while upstream still offers: refill with no bubble
    bus.allowout = 1'b1;
    tick();
    bus.data_sram_rdata = 32'h11111111;
    #1;
    chk("refill_validout", {31'h0, bus.validout}, 32'h1);
    chk("refill_pc", bus.output_pc, 32'h1c000200);
    chk("refill_wdata", bus.output_rf_wdata, 32'h00000777);

    // Back-to-back flow of four instructions
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1c001000 + 32'(k * 4), 32'h00000040 + 32'(k), 5'd20, 1'b1, 1'b0, 3'b000);
      tick();
      chk($sformatf("b2b%0d_validout", k), {31'h0, bus.validout}, 32'h1);
      chk($sformatf("b2b%0d_pc", k), bus.output_pc, 32'h1c001000 + 32'(k * 4));
    end

    // Reset asserted while an instruction is stalled
    bus.allowout = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 3'b000);
    tick();
    chk("prerst_validout", {31'h0, bus.validout}, 32'h1);
    rst = 1'b1;
    tick();
    chk("midrst_validout", {31'h0, bus.validout}, 32'h0);
    chk("midrst_allowin", {31'h0, bus.allowin}, 32'h1);
    chk("midrst_fwd_we", {31'h0, bus.fwd_we}, 32'h0);
    rst = 1'b0;
    bus.allowout = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
